// File: rtl/time_set_ctrl.sv
// Time/date setting sequencer: owns the shadow time/date registers, edits them from UP/DOWN
// while setting, and commits them with a one-cycle load strobe or drops them after an idle timeout.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | clock running normally, shadows idle, buttons ignored
// ST_SET  | setting active, UP/DOWN edit the selected shadow field
// ST_LOAD | single-cycle commit of the shadows to the timekeeping core
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_1hz_i,
    input  logic       tick_2hz_i,
    input  logic       set_req_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic [6:0] field_sel_i,
    input  logic [5:0] cur_sec_i,
    input  logic [5:0] cur_min_i,
    input  logic [4:0] cur_hour_i,
    input  logic [4:0] cur_day_i,
    input  logic [3:0] cur_mon_i,
    input  logic [6:0] cur_year_i,
    output logic       set_active_o,
    output logic       load_en_o,
    output logic [5:0] new_sec_o,
    output logic [5:0] new_min_o,
    output logic [4:0] new_hour_o,
    output logic [4:0] new_day_o,
    output logic [3:0] new_mon_o,
    output logic [6:0] new_year_o,
    output logic [6:0] blink_mask_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SET  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT_S);

    state_t     state_q, state_d;
    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hour_q, hour_d, day_q, day_d;
    logic [3:0] mon_q, mon_d;
    logic [6:0] year_q, year_d;
    logic [5:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic [6:0] fsel_q;
    logic       set_active_q, load_en_q;
    logic [6:0] blink_mask_q, blink_mask_d;

    logic       fld_ok, inc, dec, activity;
    logic [4:0] dmax_new;

    function automatic logic [4:0] dmax_f(input logic [3:0] mon, input logic [6:0] yr);
        logic [4:0] d;
        case (mon)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = (yr[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // Wrapping step inside [lo, hi]; out-of-range values fold back to the opposite end.
    function automatic logic [6:0] step_f(input logic [6:0] v, input logic [6:0] lo,
                                          input logic [6:0] hi, input logic up);
        logic [6:0] r;
        if (up) r = (v >= hi) ? lo : v + 7'd1;
        else    r = (v <= lo) ? hi : v - 7'd1;
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        day_d    = day_q;
        mon_d    = mon_q;
        year_d   = year_q;
        cnt_d    = cnt_q;
        dmax_new = 5'd31;
        fld_ok   = !field_sel_i[0] && $onehot(field_sel_i);
        inc      = up_i && !down_i;
        dec      = down_i && !up_i;
        activity = up_i || down_i || (field_sel_i != fsel_q);

        case (state_q)
            ST_RUN: begin
                if (set_req_i) begin
                    state_d = ST_SET;
                    sec_d   = cur_sec_i;
                    min_d   = cur_min_i;
                    hour_d  = cur_hour_i;
                    day_d   = cur_day_i;
                    mon_d   = cur_mon_i;
                    year_d  = cur_year_i;
                    cnt_d   = 6'd0;
                end
            end
            ST_SET: begin
                if (set_req_i) begin
                    state_d = ST_LOAD;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = ST_RUN;
                end else begin
                    if (activity)
                        cnt_d = 6'd0;
                    else if (tick_1hz_i && cnt_q != 6'h3f)
                        cnt_d = cnt_q + 6'd1;

                    if (fld_ok && (inc || dec)) begin
                        case (field_sel_i)
                            7'b0000010: sec_d  = 6'(step_f({1'b0, sec_q}, 7'd0, 7'd59, inc));
                            7'b0000100: min_d  = 6'(step_f({1'b0, min_q}, 7'd0, 7'd59, inc));
                            7'b0001000: hour_d = 5'(step_f({2'b0, hour_q}, 7'd0, 7'd23, inc));
                            7'b0010000: day_d  = 5'(step_f({2'b0, day_q}, 7'd1,
                                                           {2'b0, dmax_f(mon_q, year_q)}, inc));
                            7'b0100000: mon_d  = 4'(step_f({3'b0, mon_q}, 7'd1, 7'd12, inc));
                            7'b1000000: year_d = step_f(year_q, 7'd0, 7'd99, inc);
                            default: ;
                        endcase
                        // Changing month or year may shorten the month under the current day.
                        dmax_new = dmax_f(mon_d, year_d);
                        if ((field_sel_i[5] || field_sel_i[6]) && day_d > dmax_new)
                            day_d = dmax_new;
                    end
                end
            end
            ST_LOAD: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        phase_d      = (state_q == ST_SET && state_d == ST_SET) ? (phase_q ^ tick_2hz_i) : 1'b0;
        blink_mask_d = (state_d == ST_SET && phase_d) ? field_sel_i : 7'd0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            sec_q        <= 6'd0;
            min_q        <= 6'd0;
            hour_q       <= 5'd0;
            day_q        <= 5'd1;
            mon_q        <= 4'd1;
            year_q       <= 7'd0;
            cnt_q        <= 6'd0;
            phase_q      <= 1'b0;
            fsel_q       <= 7'b0000001;
            set_active_q <= 1'b0;
            load_en_q    <= 1'b0;
            blink_mask_q <= 7'd0;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            day_q        <= day_d;
            mon_q        <= mon_d;
            year_q       <= year_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            fsel_q       <= field_sel_i;
            set_active_q <= (state_d == ST_SET);
            load_en_q    <= (state_d == ST_LOAD);
            blink_mask_q <= blink_mask_d;
        end
    end

    assign set_active_o = set_active_q;
    assign load_en_o    = load_en_q;
    assign blink_mask_o = blink_mask_q;
    assign new_sec_o    = sec_q;
    assign new_min_o    = min_q;
    assign new_hour_o   = hour_q;
    assign new_day_o    = day_q;
    assign new_mon_o    = mon_q;
    assign new_year_o   = year_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with a short timeout (3 s).
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       tick_1hz_i = 1'b0, tick_2hz_i = 1'b0;
    logic       set_req_i = 1'b0, up_i = 1'b0, down_i = 1'b0;
    logic [6:0] field_sel_i = 7'b0000001;
    logic [5:0] cur_sec_i = 6'd56, cur_min_i = 6'd34;
    logic [4:0] cur_hour_i = 5'd12, cur_day_i = 5'd15;
    logic [3:0] cur_mon_i = 4'd6;
    logic [6:0] cur_year_i = 7'd24;
    logic       set_active_o, load_en_o;
    logic [5:0] new_sec_o, new_min_o;
    logic [4:0] new_hour_o, new_day_o;
    logic [3:0] new_mon_o;
    logic [6:0] new_year_o, blink_mask_o;

    int n_checks = 0;
    int n_fail   = 0;
    int load_cnt = 0;

    time_set_ctrl #(.TIMEOUT_S(3)) dut (
        .clk_i(clk), .reset_i(reset_i), .tick_1hz_i(tick_1hz_i), .tick_2hz_i(tick_2hz_i),
        .set_req_i(set_req_i), .up_i(up_i), .down_i(down_i), .field_sel_i(field_sel_i),
        .cur_sec_i(cur_sec_i), .cur_min_i(cur_min_i), .cur_hour_i(cur_hour_i),
        .cur_day_i(cur_day_i), .cur_mon_i(cur_mon_i), .cur_year_i(cur_year_i),
        .set_active_o(set_active_o), .load_en_o(load_en_o),
        .new_sec_o(new_sec_o), .new_min_o(new_min_o), .new_hour_o(new_hour_o),
        .new_day_o(new_day_o), .new_mon_o(new_mon_o), .new_year_o(new_year_o),
        .blink_mask_o(blink_mask_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load_en_o) load_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_up();   up_i = 1'b1;       step(); up_i = 1'b0;       endtask
    task automatic pulse_down(); down_i = 1'b1;     step(); down_i = 1'b0;     endtask
    task automatic pulse_req();  set_req_i = 1'b1;  step(); set_req_i = 1'b0;  endtask
    task automatic pulse_1hz();  tick_1hz_i = 1'b1; step(); tick_1hz_i = 1'b0; endtask
    task automatic pulse_2hz();  tick_2hz_i = 1'b1; step(); tick_2hz_i = 1'b0; endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_set_active"}, set_active_o, 0);
        check({tag, "_load_en"}, load_en_o, 0);
        check({tag, "_blink"}, blink_mask_o, 0);
        check({tag, "_sec"}, new_sec_o, 0);
        check({tag, "_min"}, new_min_o, 0);
        check({tag, "_hour"}, new_hour_o, 0);
        check({tag, "_day"}, new_day_o, 1);
        check({tag, "_mon"}, new_mon_o, 1);
        check({tag, "_year"}, new_year_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(); step();
        reset_i = 1'b0;
        step();
        check_reset_state("rst");

        // entry captures live time
        pulse_req();
        check("entry_active", set_active_o, 1);
        check("entry_load", load_en_o, 0);
        check("entry_sec", new_sec_o, 56);
        check("entry_min", new_min_o, 34);
        check("entry_hour", new_hour_o, 12);
        check("entry_day", new_day_o, 15);
        check("entry_mon", new_mon_o, 6);
        check("entry_year", new_year_o, 24);

        field_sel_i = 7'b0000010;
        for (int i = 0; i < 3; i++) pulse_up();
        check("sec_59", new_sec_o, 59);
        pulse_up();
        check("sec_wrap_up", new_sec_o, 0);

        field_sel_i = 7'b0001000;
        for (int i = 0; i < 12; i++) pulse_down();
        check("hour_0", new_hour_o, 0);
        pulse_down();
        check("hour_wrap_down", new_hour_o, 23);

        field_sel_i = 7'b0000001;
        pulse_up();
        check("view_sec", new_sec_o, 0);
        check("view_hour", new_hour_o, 23);
        field_sel_i = 7'b0000010;
        up_i = 1'b1; down_i = 1'b1; step(); up_i = 1'b0; down_i = 1'b0;
        check("updown_sec", new_sec_o, 0);

        // build 31/01/23 then walk month and year
        field_sel_i = 7'b0100000;
        for (int i = 0; i < 5; i++) pulse_down();
        check("mon_1", new_mon_o, 1);
        field_sel_i = 7'b1000000;
        pulse_down();
        check("year_23", new_year_o, 23);
        field_sel_i = 7'b0010000;
        for (int i = 0; i < 16; i++) pulse_up();
        check("day_31", new_day_o, 31);
        field_sel_i = 7'b0100000;
        pulse_up();
        check("clamp_mon", new_mon_o, 2);
        check("clamp_day_28", new_day_o, 28);
        field_sel_i = 7'b1000000;
        pulse_up();
        check("leap_year", new_year_o, 24);
        check("leap_day_kept", new_day_o, 28);
        field_sel_i = 7'b0010000;
        pulse_up();
        check("leap_day_29", new_day_o, 29);
        pulse_up();
        check("leap_day_wrap", new_day_o, 1);
        pulse_down();
        check("leap_day_back", new_day_o, 29);
        field_sel_i = 7'b1000000;
        pulse_down();
        check("unleap_year", new_year_o, 23);
        check("unleap_day_28", new_day_o, 28);

        // commit; coincident UP must be discarded
        field_sel_i = 7'b0000100;
        pulse_up();
        check("min_35", new_min_o, 35);
        set_req_i = 1'b1; up_i = 1'b1; step(); set_req_i = 1'b0; up_i = 1'b0;
        check("load_pulse", load_en_o, 1);
        check("load_active", set_active_o, 0);
        check("load_min", new_min_o, 35);
        step();
        check("post_load_en", load_en_o, 0);
        check("post_load_active", set_active_o, 0);
        check("post_load_min", new_min_o, 35);
        pulse_up();
        check("run_ignores_up", new_min_o, 35);

        // timeout, restarted once by UP
        pulse_req();
        check("to_entry", set_active_o, 1);
        check("to_entry_min", new_min_o, 34);
        pulse_1hz(); step();
        pulse_1hz(); step();
        pulse_up();
        check("to_up_min", new_min_o, 35);
        pulse_1hz(); step();
        pulse_1hz(); step();
        check("to_restarted", set_active_o, 1);
        pulse_1hz();
        check("to_at_limit", set_active_o, 1);
        step();
        check("to_left", set_active_o, 0);
        check("to_min_kept", new_min_o, 35);
        check("to_no_load", load_cnt, 1);

        // blink
        pulse_req();
        pulse_2hz();
        check("blink_on", blink_mask_o, 7'b0000100);
        pulse_2hz();
        check("blink_off", blink_mask_o, 0);

        // reset mid-SET
        reset_i = 1'b1; step(); reset_i = 1'b0;
        check_reset_state("rst_set");

        // reset mid-LOAD
        pulse_req();
        pulse_req();
        check("mid_load_en", load_en_o, 1);
        reset_i = 1'b1; step(); reset_i = 1'b0;
        check_reset_state("rst_load");

        // reset beats a commit request
        pulse_req();
        set_req_i = 1'b1; reset_i = 1'b1; step(); set_req_i = 1'b0; reset_i = 1'b0;
        check_reset_state("rst_req");
        step();
        check("final_load_cnt", load_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
